// File: rtl/regwrite_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regwrite_scheduler
// Description : Arbitrates the single GPR write port between WB and a
//               long-latency unit, and tracks LU destinations as busy.
// Revision    : 1.0 - initial release
// ============================================================================
module regwrite_scheduler #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              issue_en,
    input  logic [4:0]        issue_reg,
    input  logic              flushE,
    input  logic [4:0]        rsD,
    input  logic [4:0]        rtD,
    output logic              stallD,
    input  logic              pipe_we,
    input  logic [4:0]        pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              wb_stall,
    input  logic              lu_valid,
    input  logic [4:0]        lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [5:0]        busy_cnt,
    output logic              err
);

    localparam int WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT - 1);

    typedef enum logic [0:0] {
        PIPE_PRI = 1'b0,
        LU_FORCE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [31:0]         busy_q, busy_d;
    logic [5:0]          busy_cnt_q, busy_cnt_d;
    logic                rf_we_q, rf_we_d;
    logic [4:0]          rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic                err_q, err_d;

    logic pipe_req, pipe_acc, lu_grant, lu_acc, issue_set;
    logic hit_rs, hit_rt;

    always_comb begin
        pipe_req  = pipe_we & (pipe_waddr != 5'd0);
        issue_set = issue_en & ~flushE & (issue_reg != 5'd0);
        state_d   = state_q;
        wait_d    = wait_q;
        pipe_acc  = 1'b0;
        lu_grant  = 1'b0;
        case (state_q)
            PIPE_PRI: begin
                pipe_acc = pipe_req;
                lu_grant = lu_valid & ~pipe_req;
                if (lu_valid & pipe_req) begin
                    if (wait_q == WAIT_MAX) begin
                        state_d = LU_FORCE;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    wait_d = '0;
                end
            end
            // WB is frozen for exactly one cycle; any waiting LU result wins it.
            LU_FORCE: begin
                lu_grant = lu_valid;
                state_d  = PIPE_PRI;
                wait_d   = '0;
            end
            default: begin
                state_d = PIPE_PRI;
                wait_d  = '0;
            end
        endcase
        lu_acc = lu_valid & lu_grant;

        rf_we_d    = pipe_acc | lu_acc;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_acc) begin
            rf_waddr_d = pipe_waddr;
            rf_wdata_d = pipe_wdata;
        end else if (lu_acc) begin
            rf_waddr_d = lu_waddr;
            rf_wdata_d = lu_wdata;
        end

        // Set is applied after clear so a same-cycle reissue keeps the reg busy.
        busy_d = busy_q;
        if (lu_acc) busy_d[lu_waddr] = 1'b0;
        if (issue_set) busy_d[issue_reg] = 1'b1;
        busy_d[0] = 1'b0;

        err_d = err_q | (issue_set & busy_q[issue_reg]) | (lu_acc & ~busy_q[lu_waddr]);

        busy_cnt_d = '0;
        for (int i = 0; i < 32; i++) begin
            busy_cnt_d = busy_cnt_d + 6'(busy_d[i]);
        end

        hit_rs = (rsD != 5'd0) & (busy_q[rsD] | (issue_set & (issue_reg == rsD)));
        hit_rt = (rtD != 5'd0) & (busy_q[rtD] | (issue_set & (issue_reg == rtD)));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= PIPE_PRI;
            wait_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign stallD   = hit_rs | hit_rt;
    assign wb_stall = (state_q == LU_FORCE);
    assign lu_ready = lu_grant;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy_cnt = busy_cnt_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regwrite_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regwrite_scheduler
// Description : Scoreboard bench for regwrite_scheduler with directed and
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regwrite_scheduler;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        issue_en, flushE, pipe_we, lu_valid;
    logic [4:0]  issue_reg, rsD, rtD, pipe_waddr, lu_waddr;
    logic [31:0] pipe_wdata, lu_wdata;
    logic        stallD, wb_stall, lu_ready, rf_we, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [5:0]  busy_cnt;

    regwrite_scheduler #(.DATA_W(32), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .resetn(resetn),
        .issue_en(issue_en), .issue_reg(issue_reg), .flushE(flushE),
        .rsD(rsD), .rtD(rtD), .stallD(stallD),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .wb_stall(wb_stall),
        .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_cnt(busy_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_exp_t;

    rf_exp_t     exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    bit          m_busy[32];
    bit          m_err;
    int          m_denied;
    bit          m_force;
    logic [4:0]  m_last_addr;
    logic [31:0] m_last_data;
    bit          m_g_pipe, m_g_lu;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_busy[i];
        return c;
    endfunction

    function automatic bit model_hit(input logic [4:0] r);
        bit issuing = issue_en && !flushE && issue_reg != 0;
        return (r != 0) && (m_busy[r] || (issuing && issue_reg == r));
    endfunction

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_err = 0; m_denied = 0; m_force = 0;
        m_last_addr = '0; m_last_data = '0;
        exp_q.delete();
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        rf_exp_t e;
        bit issuing;
        #1;
        if (m_force) begin
            m_g_pipe = 0;
            m_g_lu   = lu_valid;
        end else begin
            m_g_pipe = pipe_we && pipe_waddr != 0;
            m_g_lu   = lu_valid && !m_g_pipe;
        end
        chk("lu_ready", lu_ready, m_g_lu);
        chk("wb_stall", wb_stall, m_force);
        chk("stallD", stallD, model_hit(rsD) || model_hit(rtD));

        e.we = m_g_pipe || m_g_lu;
        if (m_g_pipe) begin
            m_last_addr = pipe_waddr; m_last_data = pipe_wdata;
        end else if (m_g_lu) begin
            m_last_addr = lu_waddr; m_last_data = lu_wdata;
        end
        e.addr = m_last_addr;
        e.data = m_last_data;
        exp_q.push_back(e);

        issuing = issue_en && !flushE && issue_reg != 0;
        if (issuing && m_busy[issue_reg]) m_err = 1;
        if (m_g_lu && !m_busy[lu_waddr]) m_err = 1;
        if (m_g_lu) m_busy[lu_waddr] = 0;
        if (issuing) m_busy[issue_reg] = 1;

        if (m_force) begin
            m_force = 0; m_denied = 0;
        end else if (lu_valid && !m_g_lu) begin
            m_denied++;
            if (m_denied == STARVE) begin
                m_force = 1; m_denied = 0;
            end
        end else begin
            m_denied = 0;
        end

        @(negedge clk);
        chk("busy_cnt", busy_cnt, model_cnt());
        chk("err", err, m_err);
    endtask

    task automatic idle();
        issue_en = 0; issue_reg = 0; flushE = 0; rsD = 0; rtD = 0;
        pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_rf_waddr"}, rf_waddr, 0);
        chk({tag, "_rf_wdata"}, rf_wdata, 0);
        chk({tag, "_wb_stall"}, wb_stall, 0);
        chk({tag, "_busy_cnt"}, busy_cnt, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Entered at a falling edge; reset is asserted between clock edges.
    task automatic do_reset(input string tag);
        #2;
        idle();
        resetn = 0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    // Monitor: every regfile-port cycle is compared against the scoreboard.
    initial begin
        rf_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (resetn && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", rf_we, e.we);
                chk("rf_waddr", rf_waddr, e.addr);
                chk("rf_wdata", rf_wdata, e.data);
            end
        end
    end

    initial begin
        int stall_at;
        int next_addr;
        bit lu_has;
        logic [4:0] lu_reg;
        logic [31:0] lu_dat;
        logic [4:0] cand[$];

        idle();
        resetn = 0;
        #1;
        check_reset_values("rst0");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1;

        // Basic issue, RAW stall and LU return
        issue_en = 1; issue_reg = 5; step(); idle();
        chk("t1_busy_cnt", busy_cnt, 1);
        rsD = 5; #1 chk("t1_stallD", stallD, 1);
        lu_valid = 1; lu_waddr = 5; lu_wdata = 32'hDEADBEEF; step(); idle();
        rsD = 5; #1;
        chk("t1_rf_we", rf_we, 1);
        chk("t1_rf_waddr", rf_waddr, 5);
        chk("t1_rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("t1_stallD_drop", stallD, 0);
        step(); idle();

        // WB beats LU in a contested cycle
        issue_en = 1; issue_reg = 10; step(); idle();
        pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'h1234_5678;
        lu_valid = 1; lu_waddr = 10; lu_wdata = 32'hAAAA_0010;
        #1 chk("t2_lu_ready", lu_ready, 0);
        step(); idle();
        chk("t2_rf_waddr", rf_waddr, 3);
        chk("t2_rf_wdata", rf_wdata, 32'h1234_5678);
        lu_valid = 1; lu_waddr = 10; lu_wdata = 32'hAAAA_0010; step(); idle();

        // Starvation guard
        issue_en = 1; issue_reg = 11; step(); idle();
        stall_at = -1; next_addr = 1; lu_has = 1;
        for (int c = 0; c < 8; c++) begin
            if (wb_stall && stall_at < 0) stall_at = c;
            pipe_we = 1; pipe_waddr = 5'(next_addr); pipe_wdata = 32'h5000 + next_addr;
            lu_valid = lu_has; lu_waddr = 11; lu_wdata = 32'hBBBB_0011;
            step();
            if (m_g_pipe) next_addr++;
            if (m_g_lu) lu_has = 0;
        end
        idle();
        chk("t3_stall_cycle", stall_at, STARVE);
        chk("t3_wb_stall_clear", wb_stall, 0);

        // $0 issue / flushed issue / $0 pipe write
        issue_en = 1; issue_reg = 0; rsD = 0; step(); idle();
        issue_en = 1; issue_reg = 6; flushE = 1; rsD = 6;
        #1 chk("t4_flush_stallD", stallD, 0);
        step(); idle();
        chk("t4_busy_cnt", busy_cnt, 0);
        issue_en = 1; issue_reg = 12; step(); idle();
        pipe_we = 1; pipe_waddr = 0; pipe_wdata = 32'hFFFF_FFFF;
        lu_valid = 1; lu_waddr = 12; lu_wdata = 32'hCCCC_0012;
        #1 chk("t4_lu_ready", lu_ready, 1);
        step(); idle();
        chk("t4_rf_waddr", rf_waddr, 12);

        // WAW error, sticky
        chk("t5_err_clean", err, 0);
        issue_en = 1; issue_reg = 7; step(); idle();
        issue_en = 1; issue_reg = 7; step(); idle();
        chk("t5_err_waw", err, 1);
        lu_valid = 1; lu_waddr = 7; lu_wdata = 32'h7; step(); idle();
        step();
        chk("t5_err_sticky", err, 1);

        // Same-cycle set and clear of reg 9
        issue_en = 1; issue_reg = 9; step(); idle();
        issue_en = 1; issue_reg = 9; lu_valid = 1; lu_waddr = 9; lu_wdata = 32'h99;
        step(); idle();
        chk("t6_busy_cnt", busy_cnt, 1);
        rsD = 9; #1 chk("t6_stallD", stallD, 1);

        // Async reset in the middle of LU_FORCE
        idle();
        issue_en = 1; issue_reg = 13; step(); idle();
        for (int c = 0; c < STARVE; c++) begin
            pipe_we = 1; pipe_waddr = 5'(c + 1); pipe_wdata = 32'h600 + c;
            lu_valid = 1; lu_waddr = 13; lu_wdata = 32'hD13;
            step();
        end
        chk("t6_in_force", wb_stall, 1);
        do_reset("rst_mid");

        // LU write to a non-busy register
        lu_valid = 1; lu_waddr = 20; lu_wdata = 32'h20; step(); idle();
        chk("t5_err_nonbusy", err, 1);
        do_reset("rst_pre_rand");

        // Randomized traffic
        lu_has = 0; lu_reg = 0; lu_dat = 0;
        for (int n = 0; n < 600; n++) begin
            if (!m_force) begin
                pipe_we    = ($urandom_range(9) < 6);
                pipe_waddr = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
                pipe_wdata = $urandom;
            end
            issue_reg = 5'($urandom_range(31));
            issue_en  = ($urandom_range(3) == 0) && !m_busy[issue_reg];
            flushE    = ($urandom_range(5) == 0);
            rsD = 5'($urandom_range(31));
            rtD = 5'($urandom_range(31));
            if (!lu_has && $urandom_range(2) == 0) begin
                cand.delete();
                for (int i = 1; i < 32; i++) if (m_busy[i]) cand.push_back(5'(i));
                if (cand.size() > 0) begin
                    lu_has = 1;
                    lu_reg = cand[$urandom_range(cand.size() - 1)];
                    lu_dat = $urandom;
                end
            end
            lu_valid = lu_has; lu_waddr = lu_reg; lu_wdata = lu_dat;
            step();
            if (m_g_lu) lu_has = 0;
        end
        idle();
        step();
        step();
        @(posedge clk);
        #2;
        chk("queue_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
